// File: rtl/qgate_pkg.sv
// Shared definitions for the state-vector gate engine: opcodes, FSM states,
// instruction field layout helpers and the fixed-point multiply.
package qgate_pkg;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_H    = 3'd1,
      OP_X    = 3'd2,
      OP_Z    = 3'd3,
      OP_CNOT = 3'd4,
      OP_CZ   = 3'd5,
      OP_INIT = 3'd6,
      OP_ILL  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_APPLY,
      ST_NORM,
      ST_DONE
   } state_e;

   // 1/sqrt(2) in Q16.16
   localparam int INV_SQRT2_Q16 = 46341;

   // Instruction layout: {op[2:0], tgt[QW-1:0], ctl[QW-1:0]}
   localparam int unsigned OP_BITS = 3;
   localparam int unsigned CTL_LSB = 0;

   // Qubit index width: at least one bit even for tiny registers
   function automatic int unsigned qw_of(input int unsigned nq);
      return (nq <= 2) ? 1 : $clog2(nq);
   endfunction

   function automatic int unsigned tgt_lsb(input int unsigned qw);
      return qw;
   endfunction

   function automatic int unsigned op_lsb(input int unsigned qw);
      return 2 * qw;
   endfunction

   // Signed fixed-point multiply with floor (arithmetic) shift
   function automatic logic signed [63:0] fx_mul(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned       frac);
      logic signed [63:0] p;
      p = a * b;
      return p >>> frac;
   endfunction

endpackage

// File: rtl/qgate_butterfly.sv
// Combinational update of one amplitude pair (a0 = bit tgt clear, a1 = set).
module qgate_butterfly
   import qgate_pkg::*;
#(
   parameter int unsigned W    = 32,
   parameter int unsigned FRAC = 16,
   parameter int          K    = INV_SQRT2_Q16
) (
   input  op_e                op,
   input  logic               ctl_bit,
   input  logic signed [W-1:0] a0,
   input  logic signed [W-1:0] a1,
   output logic signed [W-1:0] a0_n,
   output logic signed [W-1:0] a1_n
);

   logic signed [W:0]  sum;
   logic signed [W:0]  diff;
   logic signed [63:0] h0;
   logic signed [63:0] h1;

   // Gate arithmetic; sum/difference carry one guard bit before the scale
   always_comb begin
      sum  = (W+1)'(a0) + (W+1)'(a1);
      diff = (W+1)'(a0) - (W+1)'(a1);
      h0   = fx_mul(64'(sum), 64'(K), FRAC);
      h1   = fx_mul(64'(diff), 64'(K), FRAC);
      a0_n = a0;
      a1_n = a1;
      unique case (op)
         OP_H: begin
            a0_n = W'(h0);
            a1_n = W'(h1);
         end
         OP_X: begin
            a0_n = a1;
            a1_n = a0;
         end
         OP_Z: a1_n = -a1;
         OP_CNOT: begin
            if (ctl_bit) begin
               a0_n = a1;
               a1_n = a0;
            end
         end
         OP_CZ: begin
            if (ctl_bit) a1_n = -a1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/qstate_gate_engine.sv
// Programmable N-qubit real state-vector engine: buffered gate program,
// one amplitude pair per cycle, registered read port and post-run norm sum.
module qstate_gate_engine
   import qgate_pkg::*;
#(
   parameter int unsigned NQ         = 2,
   parameter int unsigned W          = 32,
   parameter int unsigned FRAC       = 16,
   parameter int unsigned PROG_DEPTH = 8,
   parameter int          INV_SQRT2  = 46341,
   localparam int unsigned QW        = qw_of(NQ),
   localparam int unsigned IW        = OP_BITS + 2 * QW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                instr_valid,
   output logic                instr_ready,
   input  logic [IW-1:0]       instr_data,
   input  logic                prog_clear,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic [3:0]          gate_count,
   input  logic [NQ-1:0]       rd_addr,
   output logic signed [W-1:0] rd_amp,
   output logic signed [W-1:0] rd_prob,
   output logic [W+3:0]        total_prob
);

   localparam int unsigned NA  = 1 << NQ;
   localparam int unsigned CW  = $clog2(PROG_DEPTH + 1);
   localparam int unsigned PIW = $clog2(PROG_DEPTH);
   localparam int unsigned OPL = op_lsb(QW);
   localparam int unsigned TGL = tgt_lsb(QW);

   localparam logic [CW-1:0]       DEPTH_C   = CW'(PROG_DEPTH);
   localparam logic [NQ-2:0]       PAIR_LAST = '1;
   localparam logic [NQ-1:0]       NIDX_LAST = '1;
   localparam logic signed [W-1:0] AMP_ONE   = W'(1) << FRAC;

   state_e              state_q, state_d;
   logic [IW-1:0]       prog_q [PROG_DEPTH];
   logic [IW-1:0]       prog_d [PROG_DEPTH];
   logic [CW-1:0]       count_q, count_d;
   logic [CW-1:0]       pc_q, pc_d;
   op_e                 op_q, op_d;
   logic [QW-1:0]       tgt_q, tgt_d;
   logic [QW-1:0]       ctl_q, ctl_d;
   logic [NQ-2:0]       pair_q, pair_d;
   logic [NQ-1:0]       nidx_q, nidx_d;
   logic [W+3:0]        acc_q, acc_d;
   logic [W+3:0]        total_q, total_d;
   logic                err_q, err_d;
   logic [3:0]          gc_q, gc_d;
   logic signed [W-1:0] amp_q [NA];
   logic signed [W-1:0] amp_d [NA];
   logic signed [W-1:0] rd_amp_q, rd_amp_d;
   logic signed [W-1:0] rd_prob_q, rd_prob_d;

   logic [IW-1:0]       f_entry;
   op_e                 f_op;
   logic [QW-1:0]       f_tgt;
   logic [QW-1:0]       f_ctl;
   logic                f_ill;
   logic                tgt_bad;
   logic                ctl_bad;

   logic [NQ-1:0]       p_ext;
   logic [NQ-1:0]       p_hi;
   logic [NQ-1:0]       i0;
   logic [NQ-1:0]       i1;
   logic signed [W-1:0] bf_a0_n;
   logic signed [W-1:0] bf_a1_n;
   logic [W-1:0]        norm_prob;

   function automatic logic signed [W-1:0] prob_of(input logic signed [W-1:0] a);
      logic signed [63:0] t;
      t = fx_mul(64'(a), 64'(a), FRAC);
      return W'(t);
   endfunction

   // Decode the program entry addressed by the fetch pointer
   always_comb begin
      f_entry = prog_q[pc_q[PIW-1:0]];
      f_op    = op_e'(f_entry[OPL +: OP_BITS]);
      f_tgt   = f_entry[TGL +: QW];
      f_ctl   = f_entry[CTL_LSB +: QW];
      tgt_bad = (32'(f_tgt) >= NQ);
      ctl_bad = (32'(f_ctl) >= NQ);
      unique case (f_op)
         OP_NOP, OP_INIT:  f_ill = 1'b0;
         OP_H, OP_X, OP_Z: f_ill = tgt_bad;
         OP_CNOT, OP_CZ:   f_ill = tgt_bad | ctl_bad | (f_tgt == f_ctl);
         default:          f_ill = 1'b1;
      endcase
   end

   // Pair index: insert a 0 at bit tgt of the pair counter to form i0
   always_comb begin
      p_ext = {1'b0, pair_q};
      p_hi  = {pair_q, 1'b0};
      i0    = '0;
      for (int unsigned b = 0; b < NQ; b++) begin
         if (b < 32'(tgt_q))       i0[b] = p_ext[b];
         else if (b == 32'(tgt_q)) i0[b] = 1'b0;
         else                      i0[b] = p_hi[b];
      end
      i1 = i0 | (NQ'(1) << tgt_q);
   end

   qgate_butterfly #(
      .W    (W),
      .FRAC (FRAC),
      .K    (INV_SQRT2)
   ) u_bfly (
      .op      (op_q),
      .ctl_bit (i0[ctl_q]),
      .a0      (amp_q[i0]),
      .a1      (amp_q[i1]),
      .a0_n    (bf_a0_n),
      .a1_n    (bf_a1_n)
   );

   assign norm_prob = prob_of(amp_q[nidx_q]);

   // Next-state: program buffer, run sequencing, amplitude updates, norm sum
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pc_d    = pc_q;
      op_d    = op_q;
      tgt_d   = tgt_q;
      ctl_d   = ctl_q;
      pair_d  = pair_q;
      nidx_d  = nidx_q;
      acc_d   = acc_q;
      total_d = total_q;
      err_d   = err_q;
      gc_d    = gc_q;
      for (int unsigned i = 0; i < PROG_DEPTH; i++) prog_d[i] = prog_q[i];
      for (int unsigned i = 0; i < NA; i++) amp_d[i] = amp_q[i];

      unique case (state_q)
         ST_IDLE: begin
            // start outranks both clear and write in the same cycle
            if (start) begin
               err_d   = 1'b0;
               gc_d    = '0;
               pc_d    = '0;
               state_d = ST_FETCH;
            end else if (prog_clear) begin
               count_d = '0;
            end else if (instr_valid && instr_ready) begin
               prog_d[count_q[PIW-1:0]] = instr_data;
               count_d = count_q + CW'(1);
            end
         end
         ST_FETCH: begin
            if (pc_q == count_q) begin
               nidx_d  = '0;
               acc_d   = '0;
               state_d = ST_NORM;
            end else begin
               pc_d = pc_q + CW'(1);
               if (f_ill) begin
                  err_d = 1'b1;
               end else if (f_op != OP_NOP) begin
                  if (gc_q != 4'hF) gc_d = gc_q + 4'd1;
                  if (f_op == OP_INIT) begin
                     for (int unsigned i = 0; i < NA; i++) amp_d[i] = '0;
                     amp_d[0] = AMP_ONE;
                  end else begin
                     op_d    = f_op;
                     tgt_d   = f_tgt;
                     ctl_d   = f_ctl;
                     pair_d  = '0;
                     state_d = ST_APPLY;
                  end
               end
            end
         end
         ST_APPLY: begin
            amp_d[i0] = bf_a0_n;
            amp_d[i1] = bf_a1_n;
            pair_d    = pair_q + 1'b1;
            if (pair_q == PAIR_LAST) state_d = ST_FETCH;
         end
         ST_NORM: begin
            acc_d  = acc_q + {4'b0000, norm_prob};
            nidx_d = nidx_q + 1'b1;
            if (nidx_q == NIDX_LAST) begin
               total_d = acc_d;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Read port follows the live vector every cycle
   always_comb begin
      rd_amp_d  = amp_q[rd_addr];
      rd_prob_d = prob_of(amp_q[rd_addr]);
   end

   // State registers; reset restores |0..0> and empties the program
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         count_q   <= '0;
         pc_q      <= '0;
         op_q      <= OP_NOP;
         tgt_q     <= '0;
         ctl_q     <= '0;
         pair_q    <= '0;
         nidx_q    <= '0;
         acc_q     <= '0;
         total_q   <= '0;
         err_q     <= 1'b0;
         gc_q      <= '0;
         rd_amp_q  <= '0;
         rd_prob_q <= '0;
         for (int unsigned i = 0; i < PROG_DEPTH; i++) prog_q[i] <= '0;
         for (int unsigned i = 0; i < NA; i++) amp_q[i] <= '0;
         amp_q[0]  <= AMP_ONE;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         pc_q      <= pc_d;
         op_q      <= op_d;
         tgt_q     <= tgt_d;
         ctl_q     <= ctl_d;
         pair_q    <= pair_d;
         nidx_q    <= nidx_d;
         acc_q     <= acc_d;
         total_q   <= total_d;
         err_q     <= err_d;
         gc_q      <= gc_d;
         rd_amp_q  <= rd_amp_d;
         rd_prob_q <= rd_prob_d;
         for (int unsigned i = 0; i < PROG_DEPTH; i++) prog_q[i] <= prog_d[i];
         for (int unsigned i = 0; i < NA; i++) amp_q[i] <= amp_d[i];
      end
   end

   assign instr_ready = (state_q == ST_IDLE) && (count_q < DEPTH_C);
   assign busy        = (state_q != ST_IDLE);
   assign done        = (state_q == ST_DONE);
   assign err         = err_q;
   assign gate_count  = gc_q;
   assign rd_amp      = rd_amp_q;
   assign rd_prob     = rd_prob_q;
   assign total_prob  = total_q;

endmodule

// File: tb/tb_qstate_gate_engine.sv
// Directed bench for the gate engine: NQ=2 and NQ=3 instances, hand-computed
// Q16.16 expectations.
module tb_qstate_gate_engine;

   logic               clk = 1'b0;
   logic               rst = 1'b1;

   logic               iv2 = 1'b0, rdy2, clr2 = 1'b0, st2 = 1'b0;
   logic [4:0]         id2 = '0;
   logic               busy2, done2, err2;
   logic [3:0]         gc2;
   logic [1:0]         ra2 = '0;
   logic signed [31:0] amp2, prob2;
   logic [35:0]        tot2;

   logic               iv3 = 1'b0, rdy3, clr3 = 1'b0, st3 = 1'b0;
   logic [6:0]         id3 = '0;
   logic               busy3, done3, err3;
   logic [3:0]         gc3;
   logic [2:0]         ra3 = '0;
   logic signed [31:0] amp3, prob3;
   logic [35:0]        tot3;

   int unsigned applied = 0;
   int unsigned miscompares = 0;

   always #5 clk = ~clk;

   qstate_gate_engine #(.NQ(2)) u2 (
      .clk(clk), .rst(rst), .instr_valid(iv2), .instr_ready(rdy2), .instr_data(id2),
      .prog_clear(clr2), .start(st2), .busy(busy2), .done(done2), .err(err2),
      .gate_count(gc2), .rd_addr(ra2), .rd_amp(amp2), .rd_prob(prob2), .total_prob(tot2)
   );

   qstate_gate_engine #(.NQ(3)) u3 (
      .clk(clk), .rst(rst), .instr_valid(iv3), .instr_ready(rdy3), .instr_data(id3),
      .prog_clear(clr3), .start(st3), .busy(busy3), .done(done3), .err(err3),
      .gate_count(gc3), .rd_addr(ra3), .rd_amp(amp3), .rd_prob(prob3), .total_prob(tot3)
   );

   task automatic chk(input string tag, input longint obs, input longint exp_v);
      applied++;
      assert (obs === exp_v) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [4:0] i2(input logic [2:0] op, input logic t, input logic c);
      return {op, t, c};
   endfunction

   function automatic logic [6:0] i3(input logic [2:0] op, input logic [1:0] t, input logic [1:0] c);
      return {op, t, c};
   endfunction

   // All tasks start and end at a falling edge
   task automatic push2(input logic [4:0] d);
      id2 = d; iv2 = 1'b1;
      @(negedge clk);
      iv2 = 1'b0;
   endtask

   task automatic push3(input logic [6:0] d);
      id3 = d; iv3 = 1'b1;
      @(negedge clk);
      iv3 = 1'b0;
   endtask

   task automatic clear2();
      clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
   endtask

   task automatic run2(input logic with_write, input logic [4:0] wd);
      int unsigned n;
      logic        seen;
      id2 = wd; iv2 = with_write; st2 = 1'b1;
      @(negedge clk);
      st2 = 1'b0; iv2 = 1'b0;
      chk("busy_after_start", 64'(busy2), 1);
      seen = 1'b0; n = 0;
      while (!seen && n < 200) begin
         if (done2) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("done_seen", 64'(seen), 1);
      @(negedge clk);
      chk("done_one_cycle", 64'(done2), 0);
      chk("busy_after_done", 64'(busy2), 0);
   endtask

   task automatic run3();
      int unsigned n;
      logic        seen;
      st3 = 1'b1;
      @(negedge clk);
      st3 = 1'b0;
      seen = 1'b0; n = 0;
      while (!seen && n < 300) begin
         if (done3) seen = 1'b1;
         else begin
            @(negedge clk);
            n++;
         end
      end
      chk("done3_seen", 64'(seen), 1);
      @(negedge clk);
   endtask

   task automatic read2(input logic [1:0] a, input longint ea, input longint ep, input string tag);
      ra2 = a;
      @(negedge clk);
      chk({tag, "_amp"}, 64'(amp2), ea);
      chk({tag, "_prob"}, 64'(prob2), ep);
   endtask

   task automatic read3(input logic [2:0] a, input longint ea, input string tag);
      ra3 = a;
      @(negedge clk);
      chk(tag, 64'(amp3), ea);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Reset state
      chk("rst_busy", 64'(busy2), 0);
      chk("rst_done", 64'(done2), 0);
      chk("rst_err", 64'(err2), 0);
      chk("rst_gc", 64'(gc2), 0);
      chk("rst_total", 64'(tot2), 0);
      chk("rst_rd_amp", 64'(amp2), 0);
      chk("rst_ready", 64'(rdy2), 1);
      read2(2'd0, 65536, 65536, "rst_a0");
      read2(2'd3, 0, 0, "rst_a3");

      // Bell pair: H t0; CNOT c0 t1
      push2(i2(3'd1, 1'b0, 1'b0));
      push2(i2(3'd4, 1'b1, 1'b0));
      run2(1'b0, '0);
      chk("bell_gc", 64'(gc2), 2);
      chk("bell_err", 64'(err2), 0);
      chk("bell_total", 64'(tot2), 65536);
      read2(2'd0, 46341, 32768, "bell_a0");
      read2(2'd1, 0, 0, "bell_a1");
      read2(2'd2, 0, 0, "bell_a2");
      read2(2'd3, 46341, 32768, "bell_a3");

      // Same program on the Bell state: {0.5,-0.5,0.5,0.5} with floor on the negative term
      run2(1'b0, '0);
      chk("rerun_gc", 64'(gc2), 2);
      chk("rerun_total", 64'(tot2), 65537);
      read2(2'd0, 32768, 16384, "rerun_a0");
      read2(2'd1, -32769, 16385, "rerun_a1");
      read2(2'd2, 32768, 16384, "rerun_a2");
      read2(2'd3, 32768, 16384, "rerun_a3");

      // INIT; X t1; H t0; CZ c1 t0; Z t1 -> {0,0,-r,r}
      clear2();
      chk("clear_ready", 64'(rdy2), 1);
      push2(i2(3'd6, 1'b0, 1'b0));
      push2(i2(3'd2, 1'b1, 1'b0));
      push2(i2(3'd1, 1'b0, 1'b0));
      push2(i2(3'd5, 1'b0, 1'b1));
      push2(i2(3'd3, 1'b1, 1'b0));
      run2(1'b0, '0);
      chk("mix_gc", 64'(gc2), 5);
      chk("mix_err", 64'(err2), 0);
      chk("mix_total", 64'(tot2), 65536);
      read2(2'd0, 0, 0, "mix_a0");
      read2(2'd1, 0, 0, "mix_a1");
      read2(2'd2, -46341, 32768, "mix_a2");
      read2(2'd3, 46341, 32768, "mix_a3");

      // Full buffer: eight NOPs accepted, a ninth (illegal) entry dropped
      clear2();
      for (int i = 0; i < 8; i++) push2(i2(3'd0, 1'b0, 1'b0));
      chk("full_ready_low", 64'(rdy2), 0);
      push2(i2(3'd7, 1'b0, 1'b0));
      chk("full_ready_still_low", 64'(rdy2), 0);
      run2(1'b0, '0);
      chk("full_err", 64'(err2), 0);
      chk("full_gc", 64'(gc2), 0);
      read2(2'd2, -46341, 32768, "full_a2");

      // Illegal entries: CNOT c0 t0 and op 7 -> err, state untouched
      clear2();
      push2(i2(3'd4, 1'b0, 1'b0));
      push2(i2(3'd7, 1'b1, 1'b0));
      run2(1'b0, '0);
      chk("ill_err", 64'(err2), 1);
      chk("ill_gc", 64'(gc2), 0);
      read2(2'd3, 46341, 32768, "ill_a3");

      // start with a coincident write: write refused, err cleared
      clear2();
      run2(1'b1, i2(3'd1, 1'b0, 1'b0));
      chk("sw_err_cleared", 64'(err2), 0);
      chk("sw_gc", 64'(gc2), 0);
      chk("sw_ready", 64'(rdy2), 1);
      read2(2'd2, -46341, 32768, "sw_a2");

      // NQ=3 GHZ plus an out-of-range target that is skipped
      push3(i3(3'd1, 2'd0, 2'd0));
      push3(i3(3'd4, 2'd1, 2'd0));
      push3(i3(3'd4, 2'd2, 2'd1));
      push3(i3(3'd2, 2'd3, 2'd0));
      run3();
      chk("ghz_gc", 64'(gc3), 3);
      chk("ghz_err", 64'(err3), 1);
      chk("ghz_total", 64'(tot3), 65536);
      read3(3'd0, 46341, "ghz_a0");
      read3(3'd3, 0, "ghz_a3");
      read3(3'd4, 0, "ghz_a4");
      read3(3'd7, 46341, "ghz_a7");

      // Reset during APPLY
      push2(i2(3'd1, 1'b0, 1'b0));
      st2 = 1'b1;
      @(negedge clk);
      st2 = 1'b0;
      @(negedge clk);
      chk("apply_busy", 64'(busy2), 1);
      rst = 1'b1;
      #1;
      chk("abort_busy", 64'(busy2), 0);
      chk("abort_done", 64'(done2), 0);
      chk("abort_gc", 64'(gc2), 0);
      chk("abort_rd_amp", 64'(amp2), 0);
      @(negedge clk);
      rst = 1'b0;
      ra2 = 2'd0;
      @(negedge clk);
      chk("abort_ready", 64'(rdy2), 1);
      chk("abort_no_done", 64'(done2), 0);
      chk("abort_a0_amp", 64'(amp2), 65536);
      read2(2'd1, 0, 0, "abort_a1");

      $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
      $finish;
   end

endmodule
